inst_mem_loadable: RTL

Parametrised, writable successor to the fixed instruction ROM. It holds the program as a `DEPTH x IW` array that a test bench or boot controller streams in over a valid/ready load port. A sequencer pads unused entries with a fill word, and a ready flag tells the core when it may fetch. Fetch is a combinational read, so the single-cycle datapath is unchanged once `ProgReady` is high.

---
 rtl/inst_mem_loadable_pkg.sv | 19 +
 rtl/inst_mem_array.sv | 30 +++
 rtl/inst_mem_loadable.sv | 124 ++++++++++++
 3 files changed

// File: rtl/inst_mem_loadable_pkg.sv
// Shared definitions for the loadable instruction memory: load sequencer
// states and the default fill/idle encodings also used by the assembler
// and the core's halt decode.
package inst_mem_loadable_pkg;

    // Load sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FILL  = 2'd2,
        READY = 2'd3
    } state_t;

    // Default instruction width, and the padding and idle encodings at that width.
    localparam int                   DEF_IW        = 9;
    localparam logic [DEF_IW-1:0]    DEF_FILL_WORD = '1;  // halt encoding
    localparam logic [DEF_IW-1:0]    DEF_IDLE_WORD = '0;

endpackage : inst_mem_loadable_pkg

// File: rtl/inst_mem_array.sv
// DEPTH x IW storage array: one synchronous write port and one
// asynchronous (combinational) read port for single-cycle fetch.
module inst_mem_array #(
    parameter int IW = 9,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [IW-1:0] mem [DEPTH];

    // Write port: store one word per enabled clock edge.
    // NOTE: the array has no reset; clearing every entry would need a write
    // per location, and the sequencer already overwrites all of them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : inst_mem_array

// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory: a valid/ready load port streams the program
// in, a sequencer pads the rest with FILL_WORD, and ProgReady gates the
// combinational fetch path.
module inst_mem_loadable
    import inst_mem_loadable_pkg::*;
#(
    parameter int          IW        = DEF_IW,
    parameter int          AW        = 8,
    parameter logic [IW-1:0] FILL_WORD = DEF_FILL_WORD,
    parameter logic [IW-1:0] IDLE_WORD = DEF_IDLE_WORD
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          LoadStart,
    input  logic          LoadValid,
    input  logic          LoadLast,
    input  logic [IW-1:0] LoadData,
    output logic          LoadReady,
    input  logic [AW-1:0] InstAddress,
    output logic [IW-1:0] InstOut,
    output logic          ProgReady,
    output logic [AW:0]   WordCount,
    output logic          Overflow
);

    localparam int            DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          mem_we;
    logic [IW-1:0] mem_wdata;
    logic [IW-1:0] mem_rdata;

    // Sequencer registers with synchronous reset; the array is left untouched.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state, pointer, counter and array write control.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_wdata  = LoadData;

        if (LoadStart) begin
            // A start pulse (re)begins a load from any state; a word offered
            // in the same cycle is dropped.
            state_d    = LOAD;
            ptr_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                LOAD: begin
                    if (LoadValid) begin
                        mem_we  = 1'b1;
                        count_d = count_q + 1'b1;
                        ptr_d   = ptr_q + 1'b1;  // wraps to 0 at the top entry
                        if (ptr_q == LAST_PTR) begin
                            state_d = READY;
                        end else if (LoadLast) begin
                            state_d = FILL;
                        end
                    end
                end
                FILL: begin
                    mem_we    = 1'b1;
                    mem_wdata = FILL_WORD;
                    ptr_d     = ptr_q + 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        state_d = READY;
                    end
                end
                READY: begin
                    // Memory is full: late words are flagged, never stored.
                    if (LoadValid) begin
                        overflow_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    inst_mem_array #(
        .IW (IW),
        .AW (AW)
    ) u_array (
        .clk   (Clk),
        .we    (mem_we),
        .waddr (ptr_q),
        .wdata (mem_wdata),
        .raddr (InstAddress),
        .rdata (mem_rdata)
    );

    assign LoadReady = (state_q == LOAD);
    assign ProgReady = (state_q == READY);
    assign WordCount = count_q;
    assign Overflow  = overflow_q;
    assign InstOut   = ProgReady ? mem_rdata : IDLE_WORD;

endmodule : inst_mem_loadable
